ifft_twiddle_seq: RTL and testbench

- Upstream sequencer for the 16-point radix-2 IFFT twiddle ROMs (real/imag, 5-bit address, 16-bit data, 1-cycle synchronous read).
- Walks all stages and butterflies, drives the ROM address, and emits butterfly data-memory indices.
- Indices are time-aligned with the registered ROM output, so the downstream butterfly sees twiddle and operand indices in the same cycle.
- Includes a valid/ready stall handshake and a programmable inter-stage bubble.

---
 rtl/ifft_twiddle_seq_pkg.sv | 34 +++
 rtl/ifft_twiddle_seq_if.sv | 24 ++
 rtl/ifft_twiddle_seq_bfly_index.sv | 46 ++++
 rtl/ifft_twiddle_seq.sv | 145 ++++++++++++++
 tb/tb_ifft_twiddle_seq.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifft_twiddle_seq_pkg.sv
// Shared definitions for the 16-point IFFT twiddle sequencer:
// transform constants, FSM state encoding, butterfly command record
// and the bit-reverse helper used by the optional natural-order mode.
package ifft_pkg;

    localparam int unsigned N_POINTS  = 16;
    localparam int unsigned LOG2N     = 4;
    localparam int unsigned TW_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [1:0]       stage;
        logic [2:0]       idx;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } bf_cmd_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft_twiddle_seq_if.sv
// Butterfly/twiddle bus between the sequencer (master) and the
// twiddle ROMs plus butterfly datapath (slave).
interface ifft_twiddle_seq_if;
    import ifft_pkg::*;

    logic [TW_ADDR_W-1:0] tw_addr;
    logic                 bf_valid;
    logic                 bf_ready;
    logic [1:0]           bf_stage;
    logic [2:0]           bf_idx;
    logic [LOG2N-1:0]     idx_a;
    logic [LOG2N-1:0]     idx_b;

    modport master (
        output tw_addr, bf_valid, bf_stage, bf_idx, idx_a, idx_b,
        input  bf_ready
    );

    modport slave (
        input  tw_addr, bf_valid, bf_stage, bf_idx, idx_a, idx_b,
        output bf_ready
    );

endinterface

// File: rtl/ifft_twiddle_seq_bfly_index.sv
// Maps (stage, butterfly) to the radix-2 operand indices.
// Optional macro IFFT_TW_BITREV_EN: stage-0 indices are emitted
// bit-reversed so the input buffer can stay in natural order.
module ifft_bfly_index
    import ifft_pkg::*;
(
    input  logic [1:0]       stage_i,
    input  logic [2:0]       k_i,
    output logic [LOG2N-1:0] idx_a_o,
    output logic [LOG2N-1:0] idx_b_o
);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] lo;
    logic [LOG2N-1:0] hi;
    logic [LOG2N-1:0] a_nat;
    logic [LOG2N-1:0] b_nat;

    // Insert a zero at bit 'stage' of k to get the upper operand.
    always_comb begin
        k_ext = LOG2N'(k_i);
        span  = LOG2N'(1) << stage_i;
        lo    = k_ext & (span - LOG2N'(1));
        hi    = ((k_ext >> stage_i) << stage_i) << 1;
        a_nat = hi | lo;
        b_nat = a_nat + span;
    end

    // Final index selection (bit-reversed for stage 0 when enabled).
    always_comb begin
`ifdef IFFT_TW_BITREV_EN
        if (stage_i == 2'd0) begin
            idx_a_o = bitrev(a_nat);
            idx_b_o = bitrev(b_nat);
        end else begin
            idx_a_o = a_nat;
            idx_b_o = b_nat;
        end
`else
        idx_a_o = a_nat;
        idx_b_o = b_nat;
`endif
    end

endmodule

// File: rtl/ifft_twiddle_seq.sv
// Twiddle-ROM address and butterfly-index sequencer for a 16-point
// radix-2 IFFT. Two-deep pipeline (issue register, output register) so
// bf_* outputs line up with the registered ROM read of the same beat.
// Optional macro IFFT_TW_BITREV_EN (see ifft_bfly_index).
module ifft_twiddle_seq #(
    parameter int unsigned N_POINTS  = 16,
    parameter int unsigned LOG2N     = 4,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned STAGE_GAP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    ifft_twiddle_seq_if.master  bus
);
    import ifft_pkg::*;

    localparam int unsigned       NB         = N_POINTS / 2;
    localparam logic [2:0]        BFLY_LAST  = 3'(NB - 1);
    localparam logic [1:0]        STAGE_LAST = 2'(LOG2N - 1);
    localparam int unsigned       GW         = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0]     GAP_LAST   = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

    seq_state_e      state_q, state_d;
    logic [1:0]      stage_q;
    logic [2:0]      bfly_q;
    logic [GW-1:0]   gap_q;
    bf_cmd_t         iss_cmd, iss_q, out_q;
    logic            iss_v_q, out_v_q;
    logic [LOG2N-1:0] idx_a_w, idx_b_w;
    logic            advance;
    logic            issue;

    ifft_bfly_index u_index (
        .stage_i (stage_q),
        .k_i     (bfly_q),
        .idx_a_o (idx_a_w),
        .idx_b_o (idx_b_w)
    );

    assign advance = !out_v_q || bus.bf_ready;

    // Assemble the command for the butterfly the counter points at.
    always_comb begin
        iss_cmd       = '0;
        iss_cmd.stage = stage_q;
        iss_cmd.idx   = bfly_q;
        iss_cmd.a     = idx_a_w;
        iss_cmd.b     = idx_b_w;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (advance && bfly_q == BFLY_LAST) begin
                    if (stage_q == STAGE_LAST) state_d = DRAIN;
                    else if (STAGE_GAP > 0)    state_d = GAP;
                end
            end
            GAP: begin
                if (advance && gap_q == GAP_LAST) state_d = RUN;
            end
            DRAIN: begin
                // Last beat has left the issue stage and is being accepted.
                if (!iss_v_q && out_v_q && bus.bf_ready) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy  = (state_q == RUN) || (state_q == GAP) || (state_q == DRAIN);
        done  = (state_q == DONE);
        issue = (state_q == RUN) && advance;
    end

    // Issue counter, gap counter and the two pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            bfly_q  <= '0;
            gap_q   <= '0;
            iss_q   <= '0;
            iss_v_q <= 1'b0;
            out_q   <= '0;
            out_v_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                stage_q <= '0;
                bfly_q  <= '0;
                gap_q   <= '0;
            end else if (issue) begin
                {stage_q, bfly_q} <= {stage_q, bfly_q} + 5'd1;
            end

            if (state_q == GAP && advance) begin
                gap_q <= (gap_q == GAP_LAST) ? '0 : gap_q + GW'(1);
            end

            if (issue) begin
                iss_q   <= iss_cmd;
                iss_v_q <= 1'b1;
            end else if (advance) begin
                iss_v_q <= 1'b0;
            end

            if (advance) begin
                out_q   <= iss_q;
                out_v_q <= iss_v_q;
            end
        end
    end

    // Under stall the ROM re-reads the presented beat so its data holds.
    always_comb begin
        bus.tw_addr  = advance ? ADDR_W'({iss_q.stage, iss_q.idx})
                               : ADDR_W'({out_q.stage, out_q.idx});
        bus.bf_valid = out_v_q;
        bus.bf_stage = out_q.stage;
        bus.bf_idx   = out_q.idx;
        bus.idx_a    = out_q.a;
        bus.idx_b    = out_q.b;
    end

endmodule

// File: tb/tb_ifft_twiddle_seq.sv
// Directed bench for ifft_twiddle_seq: gap=2 and gap=0 instances, each
// with a registered twiddle ROM model driven by tw_addr.
module tb_ifft_twiddle_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    int          sel;
    int          vectors = 0;
    int          miscompares = 0;

    logic        start2, start0, busy2, done2, busy0, done0;
    logic [15:0] rom2, rom0;

    int          r_beats, r_first, r_last, r_done_c, r_done_n;
    int          got_a [32];
    int          got_b [32];
    int          first_last, first_done;

    always #5 clk = ~clk;

    ifft_twiddle_seq_if bus2 ();
    ifft_twiddle_seq_if bus0 ();

    assign start2        = (sel == 0) ? start : 1'b0;
    assign start0        = (sel == 1) ? start : 1'b0;
    assign bus2.bf_ready = (sel == 0) ? ready : 1'b1;
    assign bus0.bf_ready = (sel == 1) ? ready : 1'b1;

    ifft_twiddle_seq #(.N_POINTS(16), .LOG2N(4), .ADDR_W(5), .STAGE_GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .bus(bus2.master)
    );

    ifft_twiddle_seq #(.N_POINTS(16), .LOG2N(4), .ADDR_W(5), .STAGE_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .bus(bus0.master)
    );

    function automatic logic [15:0] rom_f(input logic [4:0] addr);
        return {addr, 3'b101, ~addr, 3'b010};
    endfunction

    always @(posedge clk) begin
        rom2 <= rom_f(bus2.tw_addr);
        rom0 <= rom_f(bus0.tw_addr);
    end

    logic        m_valid, m_busy, m_done;
    logic [4:0]  m_tw;
    logic [1:0]  m_stage;
    logic [2:0]  m_idx;
    logic [3:0]  m_a, m_b;
    logic [15:0] m_rom;

    assign m_valid = (sel == 0) ? bus2.bf_valid : bus0.bf_valid;
    assign m_busy  = (sel == 0) ? busy2 : busy0;
    assign m_done  = (sel == 0) ? done2 : done0;
    assign m_tw    = (sel == 0) ? bus2.tw_addr : bus0.tw_addr;
    assign m_stage = (sel == 0) ? bus2.bf_stage : bus0.bf_stage;
    assign m_idx   = (sel == 0) ? bus2.bf_idx : bus0.bf_idx;
    assign m_a     = (sel == 0) ? bus2.idx_a : bus0.idx_a;
    assign m_b     = (sel == 0) ? bus2.idx_b : bus0.idx_b;
    assign m_rom   = (sel == 0) ? rom2 : rom0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rev4(input int x);
        return ((x & 1) << 3) | ((x & 2) << 1) | ((x & 4) >> 1) | ((x & 8) >> 3);
    endfunction

    // Expected operand pair from the span arithmetic: split k into
    // low part (below span) and high part, double the high part.
    task automatic exp_ab(input int s, input int k, output int a, output int b);
        int span;
        span = 1 << s;
        a = (k / span) * 2 * span + (k % span);
        b = a + span;
`ifdef IFFT_TW_BITREV_EN
        if (s == 0) begin
            a = rev4(a);
            b = rev4(b);
        end
`endif
    endtask

    task automatic run_xfer(input int s, input int stall_beat, input int restart_beat,
                            input int reset_beat);
        int cyc;
        int stall_left;
        int ea, eb;
        bit restart_pend;
        sel = s;
        r_beats = 0; r_first = -1; r_last = -1; r_done_c = -1; r_done_n = 0;
        stall_left = 3;
        restart_pend = 0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            cyc++;
            if (restart_pend) begin
                start = 1'b0;
                restart_pend = 0;
            end
            if (cyc == 1) begin
                check("lat_valid_e1", m_valid, 0);
                check("lat_tw_addr_e1", m_tw, 0);
                check("busy_after_start", m_busy, 1);
            end
            if (m_done) begin
                r_done_n++;
                r_done_c = cyc;
                check("busy_low_at_done", m_busy, 0);
            end
            if (r_done_n > 0 && cyc == r_done_c + 1) break;
            if (m_valid && r_first < 0) r_first = cyc;
            if (m_valid && r_beats == reset_beat) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", m_busy, 0);
                check("rst_done", m_done, 0);
                check("rst_valid", m_valid, 0);
                check("rst_tw_addr", m_tw, 0);
                check("rst_stage", m_stage, 0);
                check("rst_idx", m_idx, 0);
                check("rst_idx_a", m_a, 0);
                check("rst_idx_b", m_b, 0);
                tick();
                check("rst_no_done", m_done, 0);
                rst_n = 1'b1;
                return;
            end
            if (m_valid && r_beats == stall_beat && stall_left > 0) begin
                ready = 1'b0;
                #1;
                exp_ab(stall_beat / 8, stall_beat % 8, ea, eb);
                check("stall_tw_addr", m_tw, stall_beat);
                check("stall_stage", m_stage, stall_beat / 8);
                check("stall_idx", m_idx, stall_beat % 8);
                check("stall_idx_a", m_a, ea);
                check("stall_idx_b", m_b, eb);
                check("stall_rom", m_rom, rom_f(5'(stall_beat)));
                stall_left--;
            end else if (m_valid) begin
                ready = 1'b1;
                if (r_beats < 32) begin
                    exp_ab(r_beats / 8, r_beats % 8, ea, eb);
                    check("beat_stage", m_stage, r_beats / 8);
                    check("beat_idx", m_idx, r_beats % 8);
                    check("beat_idx_a", m_a, ea);
                    check("beat_idx_b", m_b, eb);
                    check("beat_rom", m_rom, rom_f(5'(r_beats)));
                    got_a[r_beats] = int'(m_a);
                    got_b[r_beats] = int'(m_b);
                end
                r_beats++;
                r_last = cyc;
                if (r_beats == restart_beat) begin
                    start = 1'b1;
                    restart_pend = 1;
                end
            end else begin
                ready = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        sel   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy2, 0);
        check("reset_done", done2, 0);
        check("reset_valid", bus2.bf_valid, 0);
        check("reset_tw_addr", bus2.tw_addr, 0);
        check("reset_idx_a", bus2.idx_a, 0);
        check("reset_idx_b", bus2.idx_b, 0);
        rst_n = 1'b1;
        tick();

        // Full run, gap 2, always ready.
        run_xfer(0, -1, -1, -1);
        check("g2_beats", r_beats, 32);
        check("g2_first_valid", r_first, 2);
        check("g2_span", r_last - r_first + 1, 38);
        check("g2_done_cycle", r_done_c, 40);
        check("g2_done_pulses", r_done_n, 1);
        check("g2_s0b0_a", got_a[0], 0);
        check("g2_s0b0_b", got_b[0], 1);
        check("g2_s2b5_a", got_a[21], 9);
        check("g2_s2b5_b", got_b[21], 13);
`ifdef IFFT_TW_BITREV_EN
        check("s0b1_a", got_a[1], 4);
        check("s0b1_b", got_b[1], 12);
`else
        check("s0b1_a", got_a[1], 2);
        check("s0b1_b", got_b[1], 3);
`endif
        check("s1b1_a", got_a[9], 1);
        check("s1b1_b", got_b[9], 3);
        first_last = r_last;
        first_done = r_done_c;

        // Three-cycle stall on stage 1 butterfly 3.
        run_xfer(0, 11, -1, -1);
        check("stall_beats", r_beats, 32);
        check("stall_last", r_last, 42);
        check("stall_done_cycle", r_done_c, 43);
        check("stall_done_pulses", r_done_n, 1);

        // Start pulsed mid-run is ignored.
        run_xfer(0, -1, 5, -1);
        check("restart_beats", r_beats, 32);
        check("restart_done_cycle", r_done_c, 40);
        check("restart_done_pulses", r_done_n, 1);

        // Reset mid-run, then a clean run.
        run_xfer(0, -1, -1, 10);
        check("abort_beats", r_beats, 10);
        check("abort_done_pulses", r_done_n, 0);
        tick();
        run_xfer(0, -1, -1, -1);
        check("post_rst_beats", r_beats, 32);
        check("post_rst_done_cycle", r_done_c, 40);

        // Back-to-back transform right after the previous one.
        run_xfer(0, -1, -1, -1);
        check("b2b_beats", r_beats, 32);
        check("b2b_first_valid", r_first, 2);
        check("b2b_last_same", r_last, first_last);
        check("b2b_done_same", r_done_c, first_done);

        // Gap 0: no bubbles between stages.
        run_xfer(1, -1, -1, -1);
        check("g0_beats", r_beats, 32);
        check("g0_first_valid", r_first, 2);
        check("g0_span", r_last - r_first + 1, 32);
        check("g0_done_cycle", r_done_c, 34);
        check("g0_done_pulses", r_done_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
